mem_port_arbiter: RTL and testbench

- Sits directly downstream of the pipelined LC-3b cpu core. Merges the core's split instruction port and data port onto one unified word-wide memory/cache port.
- Arbitrates between concurrent requests and latches the winning request. Holds the request to memory until the memory responds.
- Returns read data and a one-cycle response pulse to the requesting side only.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Merges the core's instruction read port and data read/write port onto a
//   single word-wide memory port. One request is granted at a time, its
//   fields are latched and held until the memory answers, and the answer is
//   returned as a one-cycle response pulse to the side that was granted.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   inst_read_i, inst_addr_i          instruction read request
//   inst_resp_o, inst_rdata_o         instruction completion pulse / data
//   data_read_i, data_write_i         data-side read / write request
//   data_addr_i, data_wdata_i,
//   data_byte_enable_i                data-side address / write word / mask
//   data_resp_o, data_rdata_o         data completion pulse / read data
//   mem_read_o, mem_write_o           unified-port strobes
//   mem_addr_o, mem_wdata_o,
//   mem_byte_enable_o                 latched request fields
//   mem_rdata_i, mem_resp_i           memory read data / completion
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no transaction; arbitrate pending requests
// INST_BUSY | instruction read outstanding on the memory port
// DATA_BUSY | data read or write outstanding on the memory port
// RESP      | pulse the granted side's resp for one cycle
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              inst_read_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_resp_o,
    output logic [DATA_W-1:0] inst_rdata_o,

    input  logic              data_read_i,
    input  logic              data_write_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [MASK_W-1:0] data_byte_enable_i,
    output logic              data_resp_o,
    output logic [DATA_W-1:0] data_rdata_o,

    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [MASK_W-1:0] mem_byte_enable_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_data_q, last_data_d;    // 1: data side won last grant
    logic              rd_strobe_q, rd_strobe_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic inst_pend;
    logic data_pend;

    assign inst_pend = inst_read_i;
    assign data_pend = data_read_i | data_write_i;

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        rd_strobe_d  = rd_strobe_q;
        wr_strobe_d  = wr_strobe_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time gets the port.
                if (data_pend && (!inst_pend || !last_data_q)) begin
                    state_d     = DATA_BUSY;
                    last_data_d = 1'b1;
                    addr_d      = data_addr_i;
                    wdata_d     = data_wdata_i;
                    // A simultaneous read+write is served as a write.
                    rd_strobe_d = ~data_write_i;
                    wr_strobe_d = data_write_i;
                    mask_d      = data_write_i ? data_byte_enable_i : '1;
                end else if (inst_pend) begin
                    state_d     = INST_BUSY;
                    last_data_d = 1'b0;
                    addr_d      = inst_addr_i;
                    wdata_d     = '0;
                    rd_strobe_d = 1'b1;
                    wr_strobe_d = 1'b0;
                    mask_d      = '1;
                end
            end
            INST_BUSY, DATA_BUSY: begin
                if (mem_resp_i) begin
                    if (rd_strobe_q) begin
                        if (state_q == INST_BUSY) begin
                            inst_rdata_d = mem_rdata_i;
                        end else begin
                            data_rdata_d = mem_rdata_i;
                        end
                    end
                    rd_strobe_d = 1'b0;
                    wr_strobe_d = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            rd_strobe_q  <= 1'b0;
            wr_strobe_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            rd_strobe_q  <= rd_strobe_d;
            wr_strobe_q  <= wr_strobe_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_read_o        = rd_strobe_q;
    assign mem_write_o       = wr_strobe_q;
    assign mem_addr_o        = addr_q;
    assign mem_wdata_o       = wdata_q;
    assign mem_byte_enable_o = mask_q;

    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign inst_resp_o  = (state_q == RESP) && !last_data_q;
    assign data_resp_o  = (state_q == RESP) &&  last_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_read;
    logic [15:0] inst_addr;
    logic        inst_resp;
    logic [15:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic [1:0]  data_be;
    logic        data_resp;
    logic [15:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    int checks;
    int failures;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .inst_read_i        (inst_read),
        .inst_addr_i        (inst_addr),
        .inst_resp_o        (inst_resp),
        .inst_rdata_o       (inst_rdata),
        .data_read_i        (data_read),
        .data_write_i       (data_write),
        .data_addr_i        (data_addr),
        .data_wdata_i       (data_wdata),
        .data_byte_enable_i (data_be),
        .data_resp_o        (data_resp),
        .data_rdata_o       (data_rdata),
        .mem_read_o         (mem_read),
        .mem_write_o        (mem_write),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_byte_enable_o  (mem_be),
        .mem_rdata_i        (mem_rdata),
        .mem_resp_i         (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_data;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        inst_read  = 1'b0;
        inst_addr  = '0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        data_be    = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read",   {31'b0, mem_read},   32'h0);
        chk("rst_mem_write",  {31'b0, mem_write},  32'h0);
        chk("rst_mem_addr",   {16'b0, mem_addr},   32'h0);
        chk("rst_mem_wdata",  {16'b0, mem_wdata},  32'h0);
        chk("rst_mem_be",     {30'b0, mem_be},     32'h0);
        chk("rst_inst_rdata", {16'b0, inst_rdata}, 32'h0);
        chk("rst_data_rdata", {16'b0, data_rdata}, 32'h0);
        chk("rst_inst_resp",  {31'b0, inst_resp},  32'h0);
        chk("rst_data_resp",  {31'b0, data_resp},  32'h0);
        rst_n = 1'b1;
        tick();

        // Single instruction read, memory answers 3 cycles after the strobe,
        // with address hold stability while busy
        inst_read = 1'b1;
        inst_addr = 16'h0040;
        chk("ir_no_strobe_c0", {31'b0, mem_read}, 32'h0);
        tick();
        chk("ir_strobe_c1",   {31'b0, mem_read},  32'h1);
        chk("ir_nowrite_c1",  {31'b0, mem_write}, 32'h0);
        chk("ir_addr_c1",     {16'b0, mem_addr},  32'h0040);
        chk("ir_be_c1",       {30'b0, mem_be},    32'h3);
        inst_addr = 16'h0080;
        data_addr = 16'hFFFF;
        tick();
        chk("hold_addr_c2",   {16'b0, mem_addr},  32'h0040);
        data_addr = 16'h0000;
        tick();
        chk("hold_addr_c3",   {16'b0, mem_addr},  32'h0040);
        chk("hold_strobe_c3", {31'b0, mem_read},  32'h1);
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 16'h1234;
        chk("ir_noresp_c4",   {31'b0, inst_resp}, 32'h0);
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        chk("ir_resp_c5",     {31'b0, inst_resp},  32'h1);
        chk("ir_rdata_c5",    {16'b0, inst_rdata}, 32'h1234);
        chk("ir_dresp_c5",    {31'b0, data_resp},  32'h0);
        chk("ir_strobe_off",  {31'b0, mem_read},   32'h0);
        inst_read = 1'b0;
        tick();
        chk("ir_resp_once",   {31'b0, inst_resp},  32'h0);
        tick();
        chk("ir_no_regrant",  {31'b0, mem_read},   32'h0);

        // Data read
        data_read = 1'b1;
        data_addr = 16'h3004;
        tick();
        chk("dr_strobe",  {31'b0, mem_read}, 32'h1);
        chk("dr_addr",    {16'b0, mem_addr}, 32'h3004);
        chk("dr_be",      {30'b0, mem_be},   32'h3);
        mem_resp  = 1'b1;
        mem_rdata = 16'hA5A5;
        tick();
        mem_resp  = 1'b0;
        chk("dr_resp",        {31'b0, data_resp},  32'h1);
        chk("dr_rdata",       {16'b0, data_rdata}, 32'hA5A5);
        chk("dr_inst_hold",   {16'b0, inst_rdata}, 32'h1234);
        chk("dr_no_iresp",    {31'b0, inst_resp},  32'h0);
        data_read = 1'b0;
        tick();
        chk("dr_resp_once",   {31'b0, data_resp},  32'h0);

        // Data write
        data_write = 1'b1;
        data_addr  = 16'h2002;
        data_wdata = 16'hBEEF;
        data_be    = 2'b10;
        tick();
        chk("dw_strobe",  {31'b0, mem_write}, 32'h1);
        chk("dw_noread",  {31'b0, mem_read},  32'h0);
        chk("dw_addr",    {16'b0, mem_addr},  32'h2002);
        chk("dw_wdata",   {16'b0, mem_wdata}, 32'hBEEF);
        chk("dw_be",      {30'b0, mem_be},    32'h2);
        mem_resp  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_resp  = 1'b0;
        chk("dw_resp",        {31'b0, data_resp},  32'h1);
        chk("dw_rdata_hold",  {16'b0, data_rdata}, 32'hA5A5);
        chk("dw_strobe_off",  {31'b0, mem_write},  32'h0);
        data_write = 1'b0;
        tick();
        chk("dw_resp_once",   {31'b0, data_resp},  32'h0);

        // Read and write both high: served as a write
        data_read  = 1'b1;
        data_write = 1'b1;
        data_addr  = 16'h3000;
        data_be    = 2'b01;
        tick();
        chk("rw_write",   {31'b0, mem_write}, 32'h1);
        chk("rw_noread",  {31'b0, mem_read},  32'h0);
        chk("rw_addr",    {16'b0, mem_addr},  32'h3000);
        mem_resp  = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        mem_resp  = 1'b0;
        chk("rw_resp",        {31'b0, data_resp},  32'h1);
        chk("rw_rdata_hold",  {16'b0, data_rdata}, 32'hA5A5);
        data_read  = 1'b0;
        data_write = 1'b0;
        tick();
        chk("rw_resp_once",   {31'b0, data_resp},  32'h0);

        // Stray mem_resp in IDLE is ignored
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("stray_iresp",  {31'b0, inst_resp}, 32'h0);
        chk("stray_dresp",  {31'b0, data_resp}, 32'h0);
        chk("stray_strobe", {31'b0, mem_read},  32'h0);
        tick();
        chk("stray_dresp2", {31'b0, data_resp}, 32'h0);

        // Requester drops its request mid-busy: transaction still completes
        inst_read = 1'b1;
        inst_addr = 16'h0042;
        tick();
        chk("drop_strobe",   {31'b0, mem_read}, 32'h1);
        inst_read = 1'b0;
        tick();
        chk("drop_strobe2",  {31'b0, mem_read}, 32'h1);
        mem_resp  = 1'b1;
        mem_rdata = 16'h4242;
        tick();
        mem_resp  = 1'b0;
        chk("drop_resp",     {31'b0, inst_resp},  32'h1);
        chk("drop_rdata",    {16'b0, inst_rdata}, 32'h4242);
        tick();

        // Both sides request continuously from reset: DATA, INST, DATA, INST
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        inst_read = 1'b1;
        inst_addr = 16'h0100;
        data_read = 1'b1;
        data_addr = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            exp_data = (k % 2 == 0);
            tick();
            chk("alt_addr",   {16'b0, mem_addr}, exp_data ? 32'h0200 : 32'h0100);
            chk("alt_strobe", {31'b0, mem_read}, 32'h1);
            mem_resp  = 1'b1;
            mem_rdata = 16'hC000 + 16'(k);
            tick();
            mem_resp  = 1'b0;
            chk("alt_dresp",  {31'b0, data_resp}, {31'b0, exp_data});
            chk("alt_iresp",  {31'b0, inst_resp}, {31'b0, ~exp_data});
            chk("alt_rdata",  {16'b0, (exp_data ? data_rdata : inst_rdata)}, 32'hC000 + 32'(k));
            tick();
            chk("alt_idle_strobe", {31'b0, mem_read},  32'h0);
            chk("alt_idle_dresp",  {31'b0, data_resp}, 32'h0);
            chk("alt_idle_iresp",  {31'b0, inst_resp}, 32'h0);
        end
        inst_read = 1'b0;
        data_read = 1'b0;
        tick();
        tick();

        // Reset in the middle of a data write
        data_write = 1'b1;
        data_addr  = 16'h1000;
        data_wdata = 16'h1111;
        data_be    = 2'b11;
        tick();
        chk("rstw_strobe", {31'b0, mem_write}, 32'h1);
        chk("rstw_addr",   {16'b0, mem_addr},  32'h1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_write_off", {31'b0, mem_write},  32'h0);
        chk("rstw_addr_clr",  {16'b0, mem_addr},   32'h0);
        chk("rstw_rdata_clr", {16'b0, data_rdata}, 32'h0);
        data_write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("rstw_no_dresp", {31'b0, data_resp}, 32'h0);
        chk("rstw_no_iresp", {31'b0, inst_resp}, 32'h0);
        chk("rstw_no_write", {31'b0, mem_write}, 32'h0);
        tick();
        chk("rstw_no_dresp2", {31'b0, data_resp}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
